// File: rtl/vrf_read_sequencer.sv
// vrf_read_sequencer: expands an instruction's vector-group source reads into per-field VRF read packets.
module vrf_read_sequencer #(
    parameter int VRF_RPORT_NUM   = 3,
    parameter int VREG_ADDR_WIDTH = 5,
    parameter int TAG_WIDTH       = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     i_req_vld,
    output logic                                     o_req_rdy,
    input  logic [VRF_RPORT_NUM*VREG_ADDR_WIDTH-1:0] i_req_vs,
    input  logic [VRF_RPORT_NUM-1:0]                 i_req_src_en,
    input  logic [1:0]                               i_req_lmul,
    input  logic [TAG_WIDTH-1:0]                     i_req_tag,
    input  logic                                     i_flush,
    input  logic                                     i_vrf_busy,
    output logic [VRF_RPORT_NUM-1:0]                 o_pkt_vld,
    output logic [VRF_RPORT_NUM*VREG_ADDR_WIDTH-1:0] o_pkt_vaddr,
    output logic [VRF_RPORT_NUM*TAG_WIDTH-1:0]       o_pkt_rs_idx,
    output logic [VRF_RPORT_NUM*3-1:0]               o_pkt_rs_field_idx,
    output logic                                     o_seq_done_vld,
    output logic [TAG_WIDTH-1:0]                     o_seq_done_tag
);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t                                 r_state, w_state_nxt;
    logic [2:0]                             r_fcnt, w_fcnt_nxt, r_nf_m1, w_nf_m1;
    logic [VRF_RPORT_NUM*VREG_ADDR_WIDTH-1:0] r_vs;
    logic [VRF_RPORT_NUM-1:0]               r_en;
    logic [TAG_WIDTH-1:0]                   r_tag, r_done_tag, r_pend_tag;
    logic                                   r_done_vld, r_pend;
    logic                                   w_issue, w_fin, w_last, w_acc, w_zero_done;
    assign w_issue     = r_state == ISSUE;
    assign w_fin       = w_issue & (r_fcnt == r_nf_m1) & ~i_vrf_busy;
    assign o_req_rdy   = ~i_flush & (~w_issue | w_fin);
    assign w_acc       = i_req_vld & o_req_rdy;
    assign w_last      = w_fin & ~i_flush;
    assign w_zero_done = w_acc & ~|i_req_src_en;
    assign w_nf_m1     = {&i_req_lmul, i_req_lmul[1], |i_req_lmul};
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        if (i_flush) begin
            w_state_nxt = IDLE;
            w_fcnt_nxt  = 3'd0;
        end else if (w_acc) begin
            w_state_nxt = |i_req_src_en ? ISSUE : IDLE;
            w_fcnt_nxt  = 3'd0;
        end else if (w_last) begin
            w_state_nxt = IDLE;
            w_fcnt_nxt  = 3'd0;
        end else if (w_issue & ~i_vrf_busy) begin
            w_fcnt_nxt  = r_fcnt + 3'd1;
        end
    end
    // A zero-source request accepted on the edge a sequence completes yields two
    // completions at once; the younger one waits a cycle in r_pend.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fcnt     <= 3'd0;
            r_vs       <= '0;
            r_en       <= '0;
            r_nf_m1    <= 3'd0;
            r_tag      <= '0;
            r_done_vld <= 1'b0;
            r_done_tag <= '0;
            r_pend     <= 1'b0;
            r_pend_tag <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fcnt     <= w_fcnt_nxt;
            if (w_acc) begin
                r_vs    <= i_req_vs;
                r_en    <= i_req_src_en;
                r_nf_m1 <= w_nf_m1;
                r_tag   <= i_req_tag;
            end
            r_done_vld <= r_pend | w_last | w_zero_done;
            r_done_tag <= r_pend ? r_pend_tag : w_last ? r_tag : w_zero_done ? i_req_tag : '0;
            r_pend     <= w_zero_done & (r_pend | w_last);
            r_pend_tag <= i_req_tag;
        end
    end
    for (genvar i = 0; i < VRF_RPORT_NUM; i++) begin : g_port
        assign o_pkt_vld[i] = w_issue & r_en[i];
        assign o_pkt_vaddr[i*VREG_ADDR_WIDTH +: VREG_ADDR_WIDTH] =
            o_pkt_vld[i] ? r_vs[i*VREG_ADDR_WIDTH +: VREG_ADDR_WIDTH] + VREG_ADDR_WIDTH'(r_fcnt) : '0;
        assign o_pkt_rs_idx[i*TAG_WIDTH +: TAG_WIDTH] = o_pkt_vld[i] ? r_tag : '0;
        assign o_pkt_rs_field_idx[i*3 +: 3]           = o_pkt_vld[i] ? r_fcnt : '0;
    end
    assign o_seq_done_vld = r_done_vld;
    assign o_seq_done_tag = r_done_tag;
endmodule

// File: tb/tb_vrf_read_sequencer.sv
// tb_vrf_read_sequencer: directed and random checks against a request-level reference model.
module tb_vrf_read_sequencer;
    logic        clk = 1'b0;
    logic        rst, req_vld, flush, busy;
    logic [14:0] req_vs;
    logic [2:0]  req_src_en;
    logic [1:0]  req_lmul;
    logic [3:0]  req_tag;
    logic        o_req_rdy, o_seq_done_vld;
    logic [2:0]  o_pkt_vld;
    logic [14:0] o_pkt_vaddr;
    logic [11:0] o_pkt_rs_idx;
    logic [8:0]  o_pkt_rs_field_idx;
    logic [3:0]  o_seq_done_tag;
    int          n_vec = 0, n_err = 0;
    always #5 clk = ~clk;
    vrf_read_sequencer dut (
        .clk(clk), .rst(rst), .i_req_vld(req_vld), .o_req_rdy(o_req_rdy),
        .i_req_vs(req_vs), .i_req_src_en(req_src_en), .i_req_lmul(req_lmul),
        .i_req_tag(req_tag), .i_flush(flush), .i_vrf_busy(busy),
        .o_pkt_vld(o_pkt_vld), .o_pkt_vaddr(o_pkt_vaddr), .o_pkt_rs_idx(o_pkt_rs_idx),
        .o_pkt_rs_field_idx(o_pkt_rs_field_idx), .o_seq_done_vld(o_seq_done_vld),
        .o_seq_done_tag(o_seq_done_tag)
    );
    wire [44:0] dut_bus = {o_pkt_vld, o_pkt_vaddr, o_pkt_rs_idx, o_pkt_rs_field_idx,
                           o_req_rdy, o_seq_done_vld, o_seq_done_tag};
    // Reference model: the request currently being expanded, plus a queue of completions.
    bit m_act, m_dv;
    int m_vs[3], m_nf, m_tag, m_k, m_dt;
    bit m_en[3];
    int doneq[$];
    function automatic bit m_rdy();
        return !flush && (!m_act || (m_k == m_nf - 1 && !busy));
    endfunction
    function automatic logic [44:0] exp_bus();
        logic [2:0]  v;
        logic [14:0] a;
        logic [11:0] r;
        logic [8:0]  f;
        for (int i = 0; i < 3; i++) begin
            v[i]       = m_act && m_en[i];
            a[i*5 +: 5] = v[i] ? 5'((m_vs[i] + m_k) % 32) : 5'd0;
            r[i*4 +: 4] = v[i] ? 4'(m_tag) : 4'd0;
            f[i*3 +: 3] = v[i] ? 3'(m_k) : 3'd0;
        end
        return {v, a, r, f, m_rdy(), m_dv, 4'(m_dt)};
    endfunction
    task automatic step();
        bit acc;
        if (rst) begin
            m_act = 0; m_k = 0; m_dv = 0; m_dt = 0;
            doneq.delete();
            return;
        end
        acc = req_vld && m_rdy();
        if (flush) m_act = 0;
        else if (m_act && !busy) begin
            if (m_k == m_nf - 1) begin
                doneq.push_back(m_tag);
                m_act = 0;
            end else m_k++;
        end
        if (acc) begin
            if (req_src_en == 3'b000) doneq.push_back(int'(req_tag));
            else begin
                m_act = 1; m_k = 0; m_nf = 1 << req_lmul; m_tag = int'(req_tag);
                for (int i = 0; i < 3; i++) begin
                    m_vs[i] = int'(req_vs[i*5 +: 5]);
                    m_en[i] = req_src_en[i];
                end
            end
        end
        m_dv = doneq.size() != 0;
        m_dt = m_dv ? doneq.pop_front() : 0;
    endtask
    task automatic adv();
        step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive_req(input logic [14:0] vs, input logic [2:0] en, input logic [1:0] lmul, input logic [3:0] tag);
        req_vld = 1'b1; req_vs = vs; req_src_en = en; req_lmul = lmul; req_tag = tag;
    endtask
    task automatic test_reset();
        rst = 1'b1; req_vld = 1'b0; flush = 1'b0; busy = 1'b0;
        req_vs = '0; req_src_en = '0; req_lmul = '0; req_tag = '0;
        adv(); adv();
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if (dut_bus !== exp_bus() || o_req_rdy !== 1'b1 || o_pkt_vld !== 3'b000 ||
            o_seq_done_vld !== 1'b0 || o_seq_done_tag !== 4'd0 || o_pkt_vaddr !== 15'd0) begin
            n_err++;
            $display("FAIL reset got=%h exp=%h", dut_bus, exp_bus());
        end
        adv();
    endtask
    task automatic test_single();
        drive_req({5'd7, 5'd5, 5'd3}, 3'b111, 2'd0, 4'd2);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (dut_bus !== exp_bus()) begin
                n_err++;
                $display("FAIL single_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
            end
            n_vec++;
            if ((c == 1 && (o_pkt_vld !== 3'b111 || o_pkt_vaddr !== {5'd7, 5'd5, 5'd3} ||
                            o_pkt_rs_field_idx !== 9'd0 || o_pkt_rs_idx !== {3{4'd2}})) ||
                (c == 2 && (o_seq_done_vld !== 1'b1 || o_seq_done_tag !== 4'd2 || o_pkt_vld !== 3'b000))) begin
                n_err++;
                $display("FAIL single_const c=%0d got=%h", c, dut_bus);
            end
            adv();
            req_vld = 1'b0;
        end
    endtask
    task automatic test_wrap();
        drive_req({5'd0, 5'd0, 5'd28}, 3'b001, 2'd2, 4'd5);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_vec++;
            if (dut_bus !== exp_bus()) begin
                n_err++;
                $display("FAIL wrap_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
            end
            n_vec++;
            if ((c >= 1 && c <= 4 && (o_pkt_vld !== 3'b001 || o_pkt_vaddr[4:0] !== 5'(27 + c) ||
                                      o_pkt_rs_field_idx[2:0] !== 3'(c - 1))) ||
                (c == 5 && (o_seq_done_vld !== 1'b1 || o_seq_done_tag !== 4'd5 || o_pkt_vld !== 3'b000))) begin
                n_err++;
                $display("FAIL wrap_const c=%0d got=%h", c, dut_bus);
            end
            adv();
            req_vld = 1'b0;
        end
    endtask
    task automatic test_busy_hold();
        drive_req({5'd0, 5'd30, 5'd0}, 3'b010, 2'd3, 4'd7);
        for (int c = 0; c < 13; c++) begin
            busy = c >= 2 && c <= 4;
            @(negedge clk);
            n_vec++;
            if (dut_bus !== exp_bus()) begin
                n_err++;
                $display("FAIL busy_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
            end
            n_vec++;
            if ((c >= 2 && c <= 5 && (o_pkt_vld !== 3'b010 || o_pkt_vaddr[9:5] !== 5'd31 ||
                                      o_pkt_rs_field_idx[5:3] !== 3'd1)) ||
                (c == 6 && (o_pkt_vaddr[9:5] !== 5'd0 || o_pkt_rs_field_idx[5:3] !== 3'd2)) ||
                (c == 12 && (o_seq_done_vld !== 1'b1 || o_seq_done_tag !== 4'd7))) begin
                n_err++;
                $display("FAIL busy_const c=%0d got=%h", c, dut_bus);
            end
            adv();
            req_vld = 1'b0;
        end
        busy = 1'b0;
    endtask
    task automatic test_back_to_back();
        drive_req({5'd3, 5'd2, 5'd1}, 3'b111, 2'd1, 4'd3);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            n_vec++;
            if (dut_bus !== exp_bus()) begin
                n_err++;
                $display("FAIL b2b_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
            end
            n_vec++;
            if ((c == 1 && o_req_rdy !== 1'b0) ||
                (c == 2 && (o_req_rdy !== 1'b1 || o_pkt_rs_field_idx !== {3{3'd1}})) ||
                (c == 3 && (o_pkt_vaddr !== {5'd12, 5'd11, 5'd10} || o_pkt_rs_field_idx !== 9'd0 ||
                            o_seq_done_vld !== 1'b1 || o_seq_done_tag !== 4'd3)) ||
                (c == 5 && (o_seq_done_vld !== 1'b1 || o_seq_done_tag !== 4'd4))) begin
                n_err++;
                $display("FAIL b2b_const c=%0d got=%h", c, dut_bus);
            end
            adv();
            if (c == 0) drive_req({5'd12, 5'd11, 5'd10}, 3'b111, 2'd1, 4'd4);
            if (c == 2) req_vld = 1'b0;
        end
    endtask
    task automatic test_flush();
        drive_req({5'd0, 5'd0, 5'd4}, 3'b001, 2'd2, 4'd6);
        for (int c = 0; c < 6; c++) begin
            flush = c == 3;
            @(negedge clk);
            n_vec++;
            if (dut_bus !== exp_bus()) begin
                n_err++;
                $display("FAIL flush_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
            end
            n_vec++;
            if ((c == 3 && (o_req_rdy !== 1'b0 || o_pkt_rs_field_idx[2:0] !== 3'd2)) ||
                (c >= 4 && (o_pkt_vld !== 3'b000 || o_seq_done_vld !== 1'b0 || o_req_rdy !== 1'b1))) begin
                n_err++;
                $display("FAIL flush_const c=%0d got=%h", c, dut_bus);
            end
            adv();
            req_vld = 1'b0;
        end
        flush = 1'b0;
    endtask
    task automatic test_zero_en();
        drive_req(15'h1234, 3'b000, 2'd3, 4'd9);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_vec++;
            if (dut_bus !== exp_bus()) begin
                n_err++;
                $display("FAIL zero_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
            end
            n_vec++;
            if ((c == 1 && (o_seq_done_vld !== 1'b1 || o_seq_done_tag !== 4'd9 || o_pkt_vld !== 3'b000)) ||
                (c == 2 && o_seq_done_vld !== 1'b0)) begin
                n_err++;
                $display("FAIL zero_const c=%0d got=%h", c, dut_bus);
            end
            adv();
            req_vld = 1'b0;
        end
    endtask
    task automatic test_reset_mid();
        drive_req({5'd9, 5'd8, 5'd7}, 3'b101, 2'd3, 4'd11);
        for (int c = 0; c < 6; c++) begin
            rst = c == 3;
            @(negedge clk);
            n_vec++;
            if (dut_bus !== exp_bus()) begin
                n_err++;
                $display("FAIL rstmid_model c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
            end
            n_vec++;
            if (c >= 4 && (o_pkt_vld !== 3'b000 || o_seq_done_vld !== 1'b0 ||
                           o_seq_done_tag !== 4'd0 || o_req_rdy !== 1'b1)) begin
                n_err++;
                $display("FAIL rstmid_const c=%0d got=%h", c, dut_bus);
            end
            adv();
            req_vld = 1'b0;
        end
        rst = 1'b0;
    endtask
    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            rst        = $urandom_range(99) == 0;
            req_vld    = $urandom_range(1) == 1;
            req_vs     = 15'($urandom);
            req_src_en = $urandom_range(5) == 0 ? 3'b000 : 3'($urandom_range(7));
            req_lmul   = 2'($urandom);
            req_tag    = 4'($urandom);
            busy       = $urandom_range(9) < 3;
            flush      = $urandom_range(29) == 0;
            @(negedge clk);
            n_vec++;
            if (dut_bus !== exp_bus()) begin
                n_err++;
                $display("FAIL random c=%0d got=%h exp=%h", c, dut_bus, exp_bus());
            end
            adv();
        end
    endtask
    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_busy_hold();
        test_back_to_back();
        test_flush();
        test_zero_en();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
